// File: rtl/gf180mcu_fd_sc_mcu9t5v0__oai_nm_regq.sv
// ---------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu9t5v0__oai_nm_regq
//
// Registered OAI macro-cell for the 9-track 5 V library.
//   ZN = NOT( AND over groups of ( OR over the inputs of that group ) )
// The gate result goes through STAGES valid-qualified registers. A saturating
// counter records the transitions of ZN.
//
// Parameters
//   GROUPS      number of OR groups        (1..8)
//   GROUP_WIDTH inputs per group           (1..4)
//   STAGES      pipeline depth / latency   (1..4)
//   CNT_W       toggle counter width       (1..16)
//
// Ports
//   CLK     in   clock; state updates on the rising edge
//   RST     in   asynchronous active-high reset
//   E       in   capture enable / input valid
//   I       in   flat inputs; group g, bit k = I[g*GROUP_WIDTH+k]
//   CNT_CLR in   synchronous clear of TCNT (wins over a simultaneous toggle)
//   ZN      out  registered OAI result (holds between valid results)
//   VQ      out  ZN was updated by a valid result this cycle
//   TCNT    out  saturating count of ZN transitions
//
// Optional scan (macro GF180MCU_FD_SC_MCU9T5V0_OAI_NM_SCAN_EN)
//   SE      in   scan enable: data registers form a shift chain, valid bits
//                clear and TCNT freezes (CNT_CLR still honoured)
//   SI      in   scan input into the first data register
//   SO      out  scan output, the last data register
// ---------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu9t5v0__oai_nm_regq #(
    parameter int unsigned GROUPS      = 3,
    parameter int unsigned GROUP_WIDTH = 2,
    parameter int unsigned STAGES      = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          E,
    input  logic [GROUPS*GROUP_WIDTH-1:0] I,
    input  logic                          CNT_CLR,
`ifdef GF180MCU_FD_SC_MCU9T5V0_OAI_NM_SCAN_EN
    input  logic                          SE,
    input  logic                          SI,
    output logic                          SO,
`endif
    output logic                          ZN,
    output logic                          VQ,
    output logic [CNT_W-1:0]              TCNT
);

    // ---------------------------------------------------------------------
    // Combinational OAI core
    // ---------------------------------------------------------------------
    logic [GROUPS-1:0] grp_or;
    logic              oai_f;

    always_comb begin
        grp_or = '0;
        for (int unsigned g = 0; g < GROUPS; g++) begin
            grp_or[g] = |I[g*GROUP_WIDTH +: GROUP_WIDTH];
        end
        oai_f = ~&grp_or;
    end

    // ---------------------------------------------------------------------
    // Valid-qualified pipeline
    // ---------------------------------------------------------------------
    logic [STAGES:1] d_q, d_d;
    logic [STAGES:1] v_q, v_d;

    // Stage k is fed from chain bit k-1; bit 0 is the stage input and the
    // top bit is the last register, which also drives the outputs.
    logic [STAGES:0] d_chain;
    logic [STAGES:0] v_chain;

    assign d_chain = {d_q, oai_f};
    assign v_chain = {v_q, E};

`ifdef GF180MCU_FD_SC_MCU9T5V0_OAI_NM_SCAN_EN
    logic [STAGES:0] s_chain;
    assign s_chain = {d_q, SI};
    assign SO      = s_chain[STAGES];
`endif

    always_comb begin
        d_d = d_q;
        v_d = '0;
`ifdef GF180MCU_FD_SC_MCU9T5V0_OAI_NM_SCAN_EN
        if (SE) begin
            for (int unsigned k = 1; k <= STAGES; k++) begin
                d_d[k] = s_chain[k-1];
            end
        end else begin
            for (int unsigned k = 1; k <= STAGES; k++) begin
                v_d[k] = v_chain[k-1];
                if (v_chain[k-1]) begin
                    d_d[k] = d_chain[k-1];
                end
            end
        end
`else
        for (int unsigned k = 1; k <= STAGES; k++) begin
            v_d[k] = v_chain[k-1];
            if (v_chain[k-1]) begin
                d_d[k] = d_chain[k-1];
            end
        end
`endif
    end

    assign ZN = d_chain[STAGES];
    assign VQ = v_chain[STAGES];

    // ---------------------------------------------------------------------
    // Saturating toggle counter
    // ---------------------------------------------------------------------
    // zn_prev_q holds ZN as it was one edge earlier, so a change of ZN at
    // edge n is counted at edge n+1.
    logic             zn_prev_q;
    logic             zn_toggle;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;

    assign zn_toggle = (d_q[STAGES] != zn_prev_q);

    always_comb begin
        tcnt_d = tcnt_q;
        if (CNT_CLR) begin
            tcnt_d = '0;
`ifdef GF180MCU_FD_SC_MCU9T5V0_OAI_NM_SCAN_EN
        end else if (SE) begin
            tcnt_d = tcnt_q;
`endif
        end else if (zn_toggle && (tcnt_q != '1)) begin
            tcnt_d = tcnt_q + CNT_W'(1);
        end
    end

    assign TCNT = tcnt_q;

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            d_q       <= '1;
            v_q       <= '0;
            zn_prev_q <= 1'b1;
            tcnt_q    <= '0;
        end else begin
            d_q       <= d_d;
            v_q       <= v_d;
            zn_prev_q <= d_q[STAGES];
            tcnt_q    <= tcnt_d;
        end
    end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__oai_nm_regq.sv
// ---------------------------------------------------------------------------
// Testbench for gf180mcu_fd_sc_mcu9t5v0__oai_nm_regq (default parameters).
// Directed scenarios plus randomized stimulus, checked every cycle against a
// delay-queue reference model of the registered OAI cell and its counter.
// ---------------------------------------------------------------------------
module tb_gf180mcu_fd_sc_mcu9t5v0__oai_nm_regq;

    localparam int unsigned GROUPS      = 3;
    localparam int unsigned GROUP_WIDTH = 2;
    localparam int unsigned STAGES      = 2;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned IW          = GROUPS * GROUP_WIDTH;
    localparam int          CNT_MAX     = (1 << CNT_W) - 1;

    logic             CLK;
    logic             RST;
    logic             E;
    logic [IW-1:0]    I;
    logic             CNT_CLR;
    logic             ZN;
    logic             VQ;
    logic [CNT_W-1:0] TCNT;

    gf180mcu_fd_sc_mcu9t5v0__oai_nm_regq #(
        .GROUPS      (GROUPS),
        .GROUP_WIDTH (GROUP_WIDTH),
        .STAGES      (STAGES),
        .CNT_W       (CNT_W)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .E       (E),
        .I       (I),
        .CNT_CLR (CNT_CLR),
        .ZN      (ZN),
        .VQ      (VQ),
        .TCNT    (TCNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    // OAI value: 0 only when every group has at least one input set.
    function automatic bit oai_ref(input bit [IW-1:0] v);
        int unsigned mask = (1 << GROUP_WIDTH) - 1;
        for (int g = 0; g < GROUPS; g++) begin
            if (((int'(v) >> (g * GROUP_WIDTH)) & mask) == 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Each entry is {valid, result} as captured on an edge; the entry that
    // reaches the output is the one captured STAGES-1 edges before the
    // current one.
    bit [1:0] pipe[$];
    bit       m_zn;
    bit       m_vq;
    bit       m_chg;   // ZN changed on the previous edge
    int       m_tcnt;

    task automatic model_reset();
        pipe.delete();
        m_zn   = 1'b1;
        m_vq   = 1'b0;
        m_chg  = 1'b0;
        m_tcnt = 0;
    endtask

    task automatic model_edge(input bit e, input bit f, input bit clr);
        bit new_zn;
        bit new_vq;
        if (clr)                              m_tcnt = 0;
        else if (m_chg && m_tcnt < CNT_MAX)   m_tcnt = m_tcnt + 1;
        pipe.push_back({e, f});
        if (pipe.size() > STAGES) void'(pipe.pop_front());
        new_zn = m_zn;
        new_vq = 1'b0;
        if (pipe.size() == STAGES) begin
            new_vq = pipe[0][1];
            if (new_vq) new_zn = pipe[0][0];
        end
        m_chg = (new_zn != m_zn);
        m_zn  = new_zn;
        m_vq  = new_vq;
    endtask

    task automatic check_outputs(input string ctx);
        check_val({ctx, ".ZN"},   32'(ZN),   32'(m_zn));
        check_val({ctx, ".VQ"},   32'(VQ),   32'(m_vq));
        check_val({ctx, ".TCNT"}, 32'(TCNT), 32'(m_tcnt));
    endtask

    // Drive one cycle of stimulus, clock it, update the model, check.
    task automatic step(input string ctx, input bit e, input bit [IW-1:0] i, input bit clr);
        E       = e;
        I       = i;
        CNT_CLR = clr;
        @(posedge CLK);
        model_edge(e, oai_ref(i), clr);
        #1;
        check_outputs(ctx);
    endtask

    // Assert reset between edges and check outputs before any clock edge.
    task automatic async_reset(input string ctx);
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        check_outputs(ctx);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    bit [IW-1:0] r_i;
    bit          phase;

    initial begin
        RST     = 1'b1;
        E       = 1'b0;
        I       = '0;
        CNT_CLR = 1'b0;
        model_reset();
        #12;
        check_outputs("por");
        @(negedge CLK);
        RST = 1'b0;

        // Reset mid-stream, then a capture straight after release.
        for (int n = 0; n < 6; n++) step("pre_rst", 1'b1, IW'($urandom), 1'b0);
        async_reset("mid_rst");
        step("post_rst", 1'b1, 6'b01_01_10, 1'b0);
        step("post_rst", 1'b0, 6'b00_00_00, 1'b0);
        check_val("post_rst_zn0", 32'(ZN), 32'd0);
        check_val("post_rst_vq1", 32'(VQ), 32'd1);
        step("post_rst", 1'b0, 6'b00_00_00, 1'b0);

        // Single capture followed by idle cycles with all-zero inputs.
        step("single", 1'b1, 6'b10_01_01, 1'b0);
        step("single", 1'b0, 6'b00_00_00, 1'b0);
        check_val("single_zn", 32'(ZN), 32'd0);
        for (int n = 0; n < 3; n++) step("single_hold", 1'b0, 6'b00_00_00, 1'b0);
        check_val("single_hold_zn", 32'(ZN), 32'd0);

        // Group all-zero, then back-to-back streaming.
        step("grp0", 1'b1, 6'b11_00_11, 1'b0);
        step("grp0", 1'b1, 6'b01_10_11, 1'b0);
        check_val("grp0_zn1", 32'(ZN), 32'd1);
        step("grp0", 1'b0, 6'b00_00_00, 1'b0);
        check_val("grp0_zn0", 32'(ZN), 32'd0);
        step("grp0", 1'b0, 6'b00_00_00, 1'b0);

        // Valid gap: results 0, -, -, 1.
        step("gap", 1'b1, 6'b11_11_11, 1'b0);
        step("gap", 1'b0, IW'($urandom), 1'b0);
        step("gap", 1'b0, IW'($urandom), 1'b0);
        step("gap", 1'b1, 6'b00_00_00, 1'b0);
        for (int n = 0; n < 4; n++) step("gap_tail", 1'b0, IW'($urandom), 1'b0);

        // Counter saturation with an alternating stream, then a clear.
        phase = 1'b0;
        for (int n = 0; n < 300; n++) begin
            step("sat", 1'b1, phase ? 6'b11_11_11 : 6'b00_00_00, 1'b0);
            phase = ~phase;
        end
        check_val("sat_255", 32'(TCNT), 32'd255);
        step("clr", 1'b1, phase ? 6'b11_11_11 : 6'b00_00_00, 1'b1);
        phase = ~phase;
        check_val("clr_zero", 32'(TCNT), 32'd0);
        step("clr", 1'b1, phase ? 6'b11_11_11 : 6'b00_00_00, 1'b0);
        phase = ~phase;
        check_val("clr_resume", 32'(TCNT), 32'd1);

        // Randomized traffic with occasional clears and resets.
        for (int n = 0; n < 600; n++) begin
            r_i = IW'($urandom);
            if ($urandom_range(0, 79) == 0) begin
                async_reset("rnd_rst");
            end else begin
                step("rnd", ($urandom_range(0, 3) != 0), r_i, ($urandom_range(0, 40) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
